// File: rtl/switch_ctrl_pkg.sv
// Shared types for the switch select sequencer: FSM states and select encodings.
package switch_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_TICK = 2'd1,
    MUTE      = 2'd2
  } state_t;

  // Select encodings seen by the data switch
  localparam logic SEL_IN1 = 1'b1;
  localparam logic SEL_IN3 = 1'b0;

endpackage

// File: rtl/switch_wdog.sv
// Host-silence timer. Counts while enabled and clears on kick.
// expire is a one-cycle pulse in the cycle the count sits at WDOG_CYCLES-1;
// the count wraps to 0 on that edge.
module switch_wdog #(
  parameter int unsigned WDOG_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic kick,
  input  logic enable,
  output logic expire
);

  localparam int unsigned CW = (WDOG_CYCLES > 2) ? $clog2(WDOG_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(WDOG_CYCLES - 1);

  logic [CW-1:0] cnt;

  // Decoded here so the sequencer acts on the same edge the count wraps
  assign expire = enable && !kick && (cnt == LAST);

  // Timer count: kick wins, wraps after the terminal value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       cnt <= '0;
    else if (kick)    cnt <= '0;
    else if (enable)  cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
  end

endmodule

// File: rtl/switch_ctrl_seq.sv
// Select sequencer for the data switch. Accepts host select commands, aligns
// each switchover to sample_tick, blanks the path for MUTE_CYCLES cycles and
// supports periodic auto alternation.
// Optional watchdog fallback to DEFAULT_SEL: define SWITCH_CTRL_WDOG_EN.
import switch_ctrl_pkg::*;

module switch_ctrl_seq #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned MUTE_CYCLES = 4,
  parameter int unsigned WDOG_CYCLES = 1000000,
  parameter int unsigned DEFAULT_SEL = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_sel,
  input  logic                  cmd_auto,
  input  logic [15:0]           cmd_period,
  input  logic                  sample_tick,
  output logic [DATA_WIDTH-1:0] sel_out,
  output logic                  mute,
  output logic                  busy,
  output logic                  wdog_fault
);

  localparam logic       DEF       = (DEFAULT_SEL != 0);
  localparam logic [7:0] MUTE_LAST = 8'(MUTE_CYCLES - 1);

  state_t      state, state_nxt;
  logic        sel, tgt, tgt_nxt;
  logic        auto_en, auto_en_nxt;
  logic [15:0] period, period_nxt;
  logic [15:0] acnt, acnt_nxt;
  logic [7:0]  mcnt;
  logic        fault, fault_nxt;
  logic        pend, pend_nxt;   // fallback owed once the current mute ends
  logic        accept, expire;

  assign accept     = cmd_valid && cmd_ready;
  assign sel_out    = DATA_WIDTH'(sel);
  assign wdog_fault = fault;

`ifdef SWITCH_CTRL_WDOG_EN
  switch_wdog #(.WDOG_CYCLES(WDOG_CYCLES)) u_wdog (
    .clk    (clk),
    .rst_n  (rst_n),
    .kick   (accept),
    .enable (1'b1),
    .expire (expire)
  );
`else
  assign expire = 1'b0;
  logic unused_wdog;
  assign unused_wdog = (WDOG_CYCLES != 0);
`endif

  // Next-state, target and auto/watchdog bookkeeping
  always_comb begin
    state_nxt   = state;
    tgt_nxt     = tgt;
    auto_en_nxt = auto_en;
    period_nxt  = period;
    acnt_nxt    = acnt;
    fault_nxt   = fault;
    pend_nxt    = pend;
    case (state)
      IDLE: begin
        if (accept) begin
          // Command beats both auto expiry and watchdog; a same-cycle tick is dropped
          auto_en_nxt = cmd_auto && (cmd_period != 16'd0);
          period_nxt  = cmd_period;
          acnt_nxt    = '0;
          fault_nxt   = 1'b0;
          if (cmd_sel != sel) begin
            tgt_nxt   = cmd_sel;
            state_nxt = WAIT_TICK;
          end
        end else if (expire) begin
          fault_nxt   = 1'b1;
          auto_en_nxt = 1'b0;
          acnt_nxt    = '0;
          tgt_nxt     = DEF;
          if (sel != DEF) state_nxt = WAIT_TICK;
        end else if (auto_en && sample_tick) begin
          // The expiring tick is itself the boundary, so skip WAIT_TICK
          if (acnt + 16'd1 == period) begin
            acnt_nxt  = '0;
            tgt_nxt   = ~sel;
            state_nxt = MUTE;
          end else begin
            acnt_nxt  = acnt + 16'd1;
          end
        end
      end
      WAIT_TICK: begin
        if (expire) begin
          fault_nxt   = 1'b1;
          auto_en_nxt = 1'b0;
          tgt_nxt     = DEF;
        end
        if (sample_tick) state_nxt = MUTE;
      end
      MUTE: begin
        if (expire) begin
          fault_nxt   = 1'b1;
          auto_en_nxt = 1'b0;
          pend_nxt    = 1'b1;
        end
        if (mcnt == MUTE_LAST) begin
          state_nxt = IDLE;
          if (pend_nxt) begin
            pend_nxt = 1'b0;
            tgt_nxt  = DEF;
            if (sel != DEF) state_nxt = WAIT_TICK;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, counters and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      sel       <= DEF;
      tgt       <= DEF;
      auto_en   <= 1'b0;
      period    <= '0;
      acnt      <= '0;
      mcnt      <= '0;
      fault     <= 1'b0;
      pend      <= 1'b0;
      mute      <= 1'b0;
      busy      <= 1'b0;
      cmd_ready <= 1'b1;
    end else begin
      state     <= state_nxt;
      tgt       <= tgt_nxt;
      auto_en   <= auto_en_nxt;
      period    <= period_nxt;
      acnt      <= acnt_nxt;
      fault     <= fault_nxt;
      pend      <= pend_nxt;
      mute      <= (state_nxt == MUTE);
      busy      <= (state_nxt != IDLE);
      cmd_ready <= (state_nxt == IDLE);
      mcnt      <= (state == MUTE) ? mcnt + 8'd1 : 8'd0;
      // Switch in the second mute cycle so the path is already blanked
      if (state == MUTE && mcnt == 8'd0) sel <= tgt;
    end
  end

endmodule

// File: tb/tb_switch_ctrl_seq.sv
// Self-checking bench for switch_ctrl_seq. Expected select changes are queued
// when stimulus is driven; a monitor pops them as sel_out moves and checks
// the change lands on the second mute cycle.
module tb_switch_ctrl_seq;

  localparam int DW = 32;
  localparam int MC = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_sel = 1'b0;
  logic          cmd_auto = 1'b0;
  logic [15:0]   cmd_period = '0;
  logic          sample_tick = 1'b0;
  logic [DW-1:0] sel_out;
  logic          mute, busy, wdog_fault;

  int tests = 0;
  int fails = 0;

  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] prev_sel;
  int            mute_len = 0;

  switch_ctrl_seq #(
    .DATA_WIDTH(DW), .MUTE_CYCLES(MC), .WDOG_CYCLES(100), .DEFAULT_SEL(0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_sel(cmd_sel), .cmd_auto(cmd_auto), .cmd_period(cmd_period),
    .sample_tick(sample_tick), .sel_out(sel_out), .mute(mute), .busy(busy),
    .wdog_fault(wdog_fault)
  );

  always #5 clk = ~clk;

  // Scoreboard monitor: every sel_out change must be expected and mid-mute
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_sel = sel_out;
      mute_len = 0;
    end else begin
      if (mute) mute_len++; else mute_len = 0;
      if (sel_out !== prev_sel) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL sel_unexpected: got %0d, no change expected", sel_out);
        end else begin
          logic [DW-1:0] e;
          e = exp_q.pop_front();
          if (sel_out !== e || mute_len != 2) begin
            fails++;
            $display("FAIL sel_change: got %0d at mute cycle %0d, want %0d at mute cycle 2",
                     sel_out, mute_len, e);
          end
        end
        prev_sel = sel_out;
      end
    end
  end

  task automatic do_reset();
    rst_n = 1'b0; cmd_valid = 1'b0; sample_tick = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    @(negedge clk);
  endtask

  // Present a command and hold it until accepted; returns in cycle N+1
  task automatic send_cmd(input logic s, input logic a, input logic [15:0] p);
    int n = 0;
    cmd_valid = 1'b1; cmd_sel = s; cmd_auto = a; cmd_period = p;
    while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) begin
      tests++; fails++;
      $display("FAIL cmd_accept_timeout: cmd_ready=%0d after 50 cycles, want 1", cmd_ready);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // One-cycle sample strobe; returns in cycle T+1
  task automatic tick();
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    tests++; if (sel_out !== '0)     begin fails++; $display("FAIL rst_sel: got %0d want 0", sel_out); end
    tests++; if (cmd_ready !== 1'b1) begin fails++; $display("FAIL rst_ready: got %0d want 1", cmd_ready); end
    tests++; if (mute !== 1'b0)      begin fails++; $display("FAIL rst_mute: got %0d want 0", mute); end
    tests++; if (busy !== 1'b0)      begin fails++; $display("FAIL rst_busy: got %0d want 0", busy); end
    tests++; if (wdog_fault !== 1'b0) begin fails++; $display("FAIL rst_fault: got %0d want 0", wdog_fault); end
  endtask

  task automatic test_switchover();
    exp_q.push_back(DW'(1));
    send_cmd(1'b1, 1'b0, 16'd0);
    tests++; if (busy !== 1'b1)      begin fails++; $display("FAIL sw_busy: got %0d want 1", busy); end
    tests++; if (cmd_ready !== 1'b0) begin fails++; $display("FAIL sw_ready: got %0d want 0", cmd_ready); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      tests++; if (mute !== 1'b0) begin fails++; $display("FAIL sw_premute: got %0d want 0", mute); end
    end
    tick();
    for (int i = 1; i <= MC; i++) begin
      if (i > 1) @(negedge clk);
      tests++; if (mute !== 1'b1) begin fails++; $display("FAIL sw_mute%0d: got %0d want 1", i, mute); end
      tests++;
      if (sel_out !== DW'(i >= 2)) begin
        fails++; $display("FAIL sw_sel%0d: got %0d want %0d", i, sel_out, (i >= 2));
      end
    end
    @(negedge clk);
    tests++; if (mute !== 1'b0)      begin fails++; $display("FAIL sw_mute_end: got %0d want 0", mute); end
    tests++; if (cmd_ready !== 1'b1) begin fails++; $display("FAIL sw_ready_end: got %0d want 1", cmd_ready); end
    tests++; if (busy !== 1'b0)      begin fails++; $display("FAIL sw_busy_end: got %0d want 0", busy); end
  endtask

  task automatic test_same_sel();
    send_cmd(1'b1, 1'b0, 16'd0);
    tests++; if (busy !== 1'b0)      begin fails++; $display("FAIL same_busy: got %0d want 0", busy); end
    tests++; if (cmd_ready !== 1'b1) begin fails++; $display("FAIL same_ready: got %0d want 1", cmd_ready); end
    tick();
    repeat (2) @(negedge clk);
    tests++; if (mute !== 1'b0)      begin fails++; $display("FAIL same_mute: got %0d want 0", mute); end
  endtask

  task automatic test_auto();
    logic cur = 1'b1;
    send_cmd(1'b1, 1'b1, 16'd3);
    for (int k = 0; k < 9; k++) begin
      if (k % 3 == 2) begin cur = ~cur; exp_q.push_back(DW'(cur)); end
      tick();
      tests++;
      if (mute !== (k % 3 == 2)) begin
        fails++; $display("FAIL auto_mute_tick%0d: got %0d want %0d", k, mute, (k % 3 == 2));
      end
      repeat (7) @(negedge clk);
    end
    tests++; if (sel_out !== '0) begin fails++; $display("FAIL auto_final_sel: got %0d want 0", sel_out); end
    send_cmd(1'b0, 1'b0, 16'd0);
  endtask

  task automatic test_back_to_back();
    // A held command waits out the busy period
    exp_q.push_back(DW'(1));
    send_cmd(1'b1, 1'b0, 16'd0);
    cmd_valid = 1'b1; cmd_sel = 1'b0;
    exp_q.push_back(DW'(0));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests++; if (cmd_ready !== 1'b0 || busy !== 1'b1) begin
        fails++; $display("FAIL hold_ready: ready=%0d busy=%0d want 0/1", cmd_ready, busy);
      end
    end
    tick();
    send_cmd(1'b0, 1'b0, 16'd0);
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL hold_accept: busy=%0d want 1", busy); end
    tick();
    repeat (5) @(negedge clk);
    // Command and auto expiry in the same cycle
    send_cmd(1'b0, 1'b1, 16'd2);
    tick();
    @(negedge clk);
    cmd_valid = 1'b1; cmd_sel = 1'b1; cmd_auto = 1'b1; cmd_period = 16'd2; sample_tick = 1'b1;
    exp_q.push_back(DW'(1));
    @(negedge clk);
    cmd_valid = 1'b0; sample_tick = 1'b0;
    tests++; if (busy !== 1'b1 || mute !== 1'b0) begin
      fails++; $display("FAIL collide_wait: busy=%0d mute=%0d want 1/0", busy, mute);
    end
    @(negedge clk);
    tests++; if (mute !== 1'b0) begin fails++; $display("FAIL collide_tick_ignored: mute=%0d want 0", mute); end
    tick();
    repeat (5) @(negedge clk);
    tick();
    tests++; if (mute !== 1'b0) begin fails++; $display("FAIL collide_cnt_restart: mute=%0d want 0", mute); end
    repeat (3) @(negedge clk);
    exp_q.push_back(DW'(0));
    tick();
    tests++; if (mute !== 1'b1) begin fails++; $display("FAIL collide_auto2: mute=%0d want 1", mute); end
    repeat (5) @(negedge clk);
    send_cmd(1'b0, 1'b0, 16'd0);
  endtask

  task automatic test_reset_in_mute();
    exp_q.push_back(DW'(1));
    send_cmd(1'b1, 1'b0, 16'd0);
    tick();
    #2 rst_n = 1'b0;
    #1;
    exp_q.delete();
    tests++; if (sel_out !== '0 || mute !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1 || wdog_fault !== 1'b0) begin
      fails++; $display("FAIL async_rst: sel=%0d mute=%0d busy=%0d ready=%0d fault=%0d want 0/0/0/1/0",
                        sel_out, mute, busy, cmd_ready, wdog_fault);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    tests++; if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      fails++; $display("FAIL rst_resume: ready=%0d busy=%0d want 1/0", cmd_ready, busy);
    end
    exp_q.push_back(DW'(1));
    send_cmd(1'b1, 1'b0, 16'd0);
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL rst_resume_busy: got %0d want 1", busy); end
    tick();
    repeat (5) @(negedge clk);
    tests++; if (sel_out !== DW'(1)) begin fails++; $display("FAIL rst_resume_sel: got %0d want 1", sel_out); end
  endtask

`ifdef SWITCH_CTRL_WDOG_EN
  task automatic test_wdog();
    int n = 0;
    do_reset();
    exp_q.push_back(DW'(1));
    send_cmd(1'b1, 1'b1, 16'd50);
    tick();
    repeat (6) @(negedge clk);
    exp_q.push_back(DW'(0));
    while (!wdog_fault && n < 150) begin @(negedge clk); n++; end
    tests++; if (wdog_fault !== 1'b1) begin fails++; $display("FAIL wdog_set: fault=%0d want 1", wdog_fault); end
    tests++; if (busy !== 1'b1 || mute !== 1'b0) begin
      fails++; $display("FAIL wdog_fallback_wait: busy=%0d mute=%0d want 1/0", busy, mute);
    end
    tick();
    @(negedge clk);
    tests++; if (sel_out !== '0) begin fails++; $display("FAIL wdog_sel: got %0d want 0", sel_out); end
    repeat (4) @(negedge clk);
    // Auto must be off: 55 idle ticks with period 50 produce no toggle
    for (int i = 0; i < 55; i++) begin tick(); @(negedge clk); end
    tests++; if (wdog_fault !== 1'b1) begin fails++; $display("FAIL wdog_sticky: got %0d want 1", wdog_fault); end
    exp_q.push_back(DW'(1));
    send_cmd(1'b1, 1'b0, 16'd0);
    tests++; if (wdog_fault !== 1'b0) begin fails++; $display("FAIL wdog_clear: got %0d want 0", wdog_fault); end
    tick();
    repeat (5) @(negedge clk);
  endtask
`else
  task automatic test_wdog();
    do_reset();
    repeat (150) @(negedge clk);
    tests++; if (wdog_fault !== 1'b0 || busy !== 1'b0) begin
      fails++; $display("FAIL wdog_off: fault=%0d busy=%0d want 0/0", wdog_fault, busy);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_switchover();
    test_same_sel();
    test_auto();
    test_back_to_back();
    test_reset_in_mute();
    test_wdog();
    repeat (3) @(negedge clk);
    tests++;
    if (exp_q.size() != 0) begin
      fails++; $display("FAIL scoreboard_drain: %0d changes outstanding, want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
